smc_seq_ctrl: RTL and testbench

- Sequencer for the SMC weighted-sum selection datapath.
- Accepts six unsigned samples serially plus a mode, and keeps them sorted descending as they arrive (insertion sort).
- Presents the sorted set and mode to the combinational datapath, captures its 10-bit result, and returns it with a one-cycle valid pulse.
- Sits between the SMC input stream and the datapath instance.

---
 rtl/smc_pkg.sv | 19 +
 rtl/smc_sort_insert.sv | 62 ++++++
 rtl/smc_seq_ctrl.sv | 95 +++++++++
 tb/tb_smc_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// Shared types and constants for the SMC sequencer and its sorted operand store.
package smc_pkg;

    localparam int SMC_DW  = 10;
    localparam int SMC_NUM = 6;

    localparam logic [1:0] MODE_LO_SUM  = 2'b00;
    localparam logic [1:0] MODE_LO_WSUM = 2'b01;
    localparam logic [1:0] MODE_HI_SUM  = 2'b10;
    localparam logic [1:0] MODE_HI_WSUM = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/smc_sort_insert.sv
// Descending sorted register array filled one value at a time by insertion.
// clr together with ins_en starts a fresh set, so the value lands in slot 0.
module smc_sort_insert
    import smc_pkg::*;
#(
    parameter int DW  = SMC_DW,
    parameter int NUM = SMC_NUM
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     ins_en,
    input  logic [DW-1:0]            ins_data,
    output logic [NUM-1:0][DW-1:0]   sorted
);

    logic [NUM-1:0][DW-1:0] arr;
    logic [NUM-1:0][DW-1:0] base;
    logic [NUM-1:0][DW-1:0] shifted;
    logic [NUM-1:0][DW-1:0] nxt;
    logic [NUM-1:0]         vld;
    logic [NUM-1:0]         base_vld;
    logic [NUM-1:0]         ge;
    logic [NUM-1:0]         prev_ge;

    // ge is a prefix of held entries >= the new value; the value goes right after it,
    // which places it behind equal entries.
    always_comb begin
        base     = clr ? '0 : arr;
        base_vld = clr ? '0 : vld;
        shifted  = {base[NUM-2:0], {DW{1'b0}}};
        for (int i = 0; i < NUM; i++) begin
            ge[i] = base_vld[i] && (base[i] >= ins_data);
        end
        prev_ge = {ge[NUM-2:0], 1'b1};
        for (int i = 0; i < NUM; i++) begin
            if (ge[i]) begin
                nxt[i] = base[i];
            end else if (prev_ge[i]) begin
                nxt[i] = ins_data;
            end else begin
                nxt[i] = shifted[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr <= '0;
            vld <= '0;
        end else if (ins_en) begin
            arr <= nxt;
            vld <= {base_vld[NUM-2:0], 1'b1};
        end else if (clr) begin
            arr <= '0;
            vld <= '0;
        end
    end

    assign sorted = arr;

endmodule

// File: rtl/smc_seq_ctrl.sv
// Collects six samples into a sorted operand set, waits one cycle for the
// combinational datapath, then returns its result with a one-cycle strobe.
module smc_seq_ctrl
    import smc_pkg::*;
#(
    parameter int DW  = SMC_DW,
    parameter int NUM = SMC_NUM
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_mode,
    output logic          busy,
    output logic [1:0]    dp_mode,
    output logic [DW-1:0] dp_n0,
    output logic [DW-1:0] dp_n1,
    output logic [DW-1:0] dp_n2,
    output logic [DW-1:0] dp_n3,
    output logic [DW-1:0] dp_n4,
    output logic [DW-1:0] dp_n5,
    input  logic [DW-1:0] dp_out,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    localparam logic [2:0] LAST_IDX = 3'(NUM - 1);

    state_t                 state;
    logic [2:0]             count;
    logic                   take;
    logic                   first;
    logic [NUM-1:0][DW-1:0] sorted;

    assign busy  = (state == EVAL) || (state == OUT);
    assign take  = in_valid && !busy;
    assign first = take && (state == IDLE);

    smc_sort_insert #(.DW(DW), .NUM(NUM)) u_sort (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (first),
        .ins_en   (take),
        .ins_data (in_data),
        .sorted   (sorted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 3'd0;
            dp_mode   <= 2'b00;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dp_mode <= in_mode;
                        count   <= 3'd1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (count == LAST_IDX) begin
                            count <= 3'd0;
                            state <= EVAL;
                        end else begin
                            count <= count + 3'd1;
                        end
                    end
                end
                EVAL: begin
                    out_data  <= dp_out;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dp_n0 = sorted[0];
    assign dp_n1 = sorted[1];
    assign dp_n2 = sorted[2];
    assign dp_n3 = sorted[3];
    assign dp_n4 = sorted[4];
    assign dp_n5 = sorted[5];

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Bench for smc_seq_ctrl: a behavioural datapath stub, a job driver that queues
// expected results, and an independent monitor that pops them on out_valid.
module tb_smc_seq_ctrl;

    localparam int DW = 10;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          busy;
    logic [1:0]    dp_mode;
    logic [DW-1:0] dp_n0, dp_n1, dp_n2, dp_n3, dp_n4, dp_n5;
    logic [DW-1:0] dp_out;
    logic          out_valid;
    logic [DW-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [69:0] exp_q[$];
    logic [9:0]  job_v[6];
    int          job_gap[6];

    smc_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .busy      (busy),
        .dp_mode   (dp_mode),
        .dp_n0     (dp_n0),
        .dp_n1     (dp_n1),
        .dp_n2     (dp_n2),
        .dp_n3     (dp_n3),
        .dp_n4     (dp_n4),
        .dp_n5     (dp_n5),
        .dp_out    (dp_out),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Datapath behaviour: low half (modes 0x) uses the three smallest operands,
    // high half (1x) the three largest; odd modes weight them 3,4,5 in order.
    function automatic logic [9:0] dp_fn(input logic [1:0] mode, input int a, input int b,
                                         input int c, input int d, input int e, input int f);
        int x0, x1, x2, acc;
        x0 = mode[1] ? a : d;
        x1 = mode[1] ? b : e;
        x2 = mode[1] ? c : f;
        acc = mode[0] ? (3 * x0 + 4 * x1 + 5 * x2) : (x0 + x1 + x2);
        return 10'(acc % 1024);
    endfunction

    always_comb dp_out = dp_fn(dp_mode, dp_n0, dp_n1, dp_n2, dp_n3, dp_n4, dp_n5);

    function automatic logic [69:0] model(input logic [1:0] mode);
        int s[6];
        int t;
        logic [69:0] r;
        for (int i = 0; i < 6; i++) s[i] = job_v[i];
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (s[j] < s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        r = {10'(s[0]), 10'(s[1]), 10'(s[2]), 10'(s[3]), 10'(s[4]), 10'(s[5]),
             dp_fn(mode, s[0], s[1], s[2], s[3], s[4], s[5])};
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [69:0] e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[9:0]);
                chk("dp_n0", dp_n0, e[69:60]);
                chk("dp_n1", dp_n1, e[59:50]);
                chk("dp_n2", dp_n2, e[49:40]);
                chk("dp_n3", dp_n3, e[39:30]);
                chk("dp_n4", dp_n4, e[29:20]);
                chk("dp_n5", dp_n5, e[19:10]);
            end
        end
    end

    // driver: job_v/job_gap hold the job; extra keeps in_valid high 0..2 cycles past sample 5
    task automatic send_job(input logic [1:0] mode, input bit toggle, input int extra);
        exp_q.push_back(model(mode));
        for (int i = 0; i < 6; i++) begin
            repeat (job_gap[i]) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 10'($urandom_range(0, 1023));
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = job_v[i];
            in_mode  = (i > 0 && toggle) ? 2'($urandom_range(0, 3)) : mode;
        end
        @(negedge clk);
        in_valid = (extra > 0);
        in_data  = 10'($urandom_range(0, 1023));
        in_mode  = 2'($urandom_range(0, 3));
        chk("eval_busy", busy, 1);
        chk("eval_no_out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = (extra > 1);
        in_data  = 10'($urandom_range(0, 1023));
        chk("out_busy", busy, 1);
        chk("latency_out_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("out_valid_one_cycle", out_valid, 0);
    endtask

    task automatic set_job(input int a, input int b, input int c, input int d, input int e, input int f);
        job_v[0] = 10'(a); job_v[1] = 10'(b); job_v[2] = 10'(c);
        job_v[3] = 10'(d); job_v[4] = 10'(e); job_v[5] = 10'(f);
        for (int i = 0; i < 6; i++) job_gap[i] = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dp_mode", dp_mode, 0);
        chk("rst_dp_n0", dp_n0, 0);
        chk("rst_dp_n5", dp_n5, 0);
        rst_n = 1'b1;

        // directed jobs
        set_job(5, 1, 9, 3, 7, 2);
        send_job(2'b00, 1'b0, 0);
        send_job(2'b01, 1'b0, 0);
        send_job(2'b10, 1'b0, 0);
        send_job(2'b11, 1'b0, 0);
        set_job(1023, 1023, 1023, 1023, 1023, 1023);
        send_job(2'b11, 1'b0, 0);
        set_job(4, 4, 4, 4, 4, 4);
        send_job(2'b10, 1'b0, 0);
        set_job(8, 6, 4, 2, 0, 1);
        job_gap[1] = 1; job_gap[2] = 2;
        send_job(2'b10, 1'b1, 0);
        chk("dp_mode_held", dp_mode, 2'b10);
        set_job(3, 9, 0, 5, 5, 1);
        send_job(2'b01, 1'b0, 2);
        repeat (4) @(negedge clk);

        // reset mid-job after three samples
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 10'(1000 - i);
            in_mode  = 2'b11;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_dp_n0", dp_n0, 0);
        chk("midrst_dp_n2", dp_n2, 0);
        chk("midrst_dp_mode", dp_mode, 0);
        chk("midrst_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        set_job(2, 6, 1, 0, 3, 5);
        send_job(2'b10, 1'b0, 0);

        // randomized jobs
        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i < 6; i++) begin
                job_v[i]   = (j % 2 == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(0, 1023));
                job_gap[i] = $urandom_range(0, 2);
            end
            send_job(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        repeat (6) @(negedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
